// File: rtl/fetch_ctrl.sv
// fetch_ctrl -- instruction-fetch sequencer for the 4-stage pipeline.
//
// Owns the program counter that addresses the instruction memory and
// registers each fetched instruction into the IF/ID pipeline register.
// Handles decode stalls, jumps resolved from IF/ID, later-stage redirects
// and program halt.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   instr_in     instruction read combinationally from memory at pc_out
//   stall        hazard stall from decode; holds PC and IF/ID
//   redir_valid  redirect request from a later stage
//   redir_pc     redirect target (low log2(DEPTH) bits used)
//   pc_out       current fetch address
//   ifid_instr   IF/ID instruction
//   ifid_pc      PC of ifid_instr
//   ifid_valid   IF/ID holds a live instruction
//   halted       halt instruction has retired from IF/ID
//
// States:
//   state  | meaning
//   S_IDLE | one wait cycle after reset release while memory finishes loading
//   S_RUN  | normal fetch, priority redirect > stall > halt > jump > fetch
//   S_HALT | halt retired; everything frozen until reset

module fetch_ctrl #(
  parameter int DEPTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] instr_in,
  input  logic       stall,
  input  logic       redir_valid,
  input  logic [7:0] redir_pc,
  output logic [7:0] pc_out,
  output logic [7:0] ifid_instr,
  output logic [7:0] ifid_pc,
  output logic       ifid_valid,
  output logic       halted
);

  localparam logic [7:0] PC_MASK  = 8'(DEPTH - 1);
  localparam logic [7:0] HALT_OP  = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] instr_q, instr_d;
  logic [7:0] ipc_q, ipc_d;
  logic       valid_q, valid_d;
  logic       halted_q, halted_d;

  logic       ifid_is_halt;
  logic       ifid_is_jump;
  logic [7:0] jump_target;
  logic [7:0] redir_target;
  logic [7:0] pc_inc;

  // Decode of the instruction currently sitting in IF/ID. 8'hFF shares the
  // jump opcode, so halt has to be excluded from the jump test.
  assign ifid_is_halt = valid_q && (instr_q == HALT_OP);
  assign ifid_is_jump = valid_q && (instr_q[7:6] == 2'b11) && (instr_q != HALT_OP);

  assign jump_target  = {2'b00, instr_q[5:0]} & PC_MASK;
  assign redir_target = redir_pc & PC_MASK;
  assign pc_inc       = (pc_q + 8'd1) & PC_MASK;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      pc_q     <= 8'd0;
      instr_q  <= 8'd0;
      ipc_q    <= 8'd0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      ipc_q    <= ipc_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    ipc_d    = ipc_q;
    valid_d  = valid_q;
    halted_d = halted_q;

    unique case (state_q)
      S_IDLE: begin
        // No fetch in the wait cycle; stall and redirect are ignored.
        state_d = S_RUN;
        valid_d = 1'b0;
      end

      S_RUN: begin
        if (redir_valid) begin
          // Redirect wins over stall and over any jump/halt waiting in IF/ID.
          pc_d    = redir_target;
          valid_d = 1'b0;
        end else if (stall) begin
          // Hold everything; a jump or halt in IF/ID resolves after release.
        end else if (ifid_is_halt) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
          valid_d  = 1'b0;
        end else if (ifid_is_jump) begin
          // Dropping valid squashes the fall-through fetched this cycle.
          pc_d    = jump_target;
          valid_d = 1'b0;
        end else begin
          instr_d = instr_in;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_inc;
        end
      end

      S_HALT: begin
        valid_d  = 1'b0;
        halted_d = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign pc_out     = pc_q;
  assign ifid_instr = instr_q;
  assign ifid_pc    = ipc_q;
  assign ifid_valid = valid_q;
  assign halted     = halted_q;

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the 4-stage pipelined processor. It owns the program counter that addresses the 8-bit instruction memory and registers each fetched instruction into the IF/ID pipeline register. It handles pipeline stalls, in-fetch jumps, later-stage redirects and program halt. It sits between the instruction memory and the decode stage.

## Interface

- DEPTH, 32, instruction memory depth in words; power of two, at most 64; PC wraps modulo DEPTH.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr_in  in  8  instruction read from memory at pc_out (combinational memory read).
- stall  in  1  hazard stall from decode; holds PC and IF/ID.
- redir_valid  in  1  redirect request from a later stage.
- redir_pc  in  8  redirect target; only the low log2(DEPTH) bits are used.
- pc_out  out  8  current fetch address to instruction memory.
- ifid_instr  out  8  IF/ID instruction.
- ifid_pc  out  8  PC of ifid_instr.
- ifid_valid  out  1  IF/ID holds a live instruction.
- halted  out  1  halt instruction has retired from IF/ID.

## Operation

- Instruction fields: opcode = instr[7:6].
- Jump: opcode 2'b11 and instr != 8'hFF. Target = instr[5:0] & (DEPTH-1).
- Halt: instr == 8'hFF.
- Reset (reset low, asynchronous): pc_out=0, ifid_instr=0, ifid_pc=0, ifid_valid=0, halted=0, state=IDLE.
- States: IDLE, RUN, HALT.
  - IDLE: one wait cycle after reset release so the instruction memory can finish loading. No fetch occurs. Transition to RUN on the next edge unconditionally; stall and redir_valid are ignored.
  - RUN: per-edge actions follow the priority list below.
  - HALT: pc_out, ifid_instr and ifid_pc hold; ifid_valid=0; halted=1. HALT is left only by reset. redir_valid and stall are ignored.
- RUN priority, evaluated each rising edge, highest first:
  1. redir_valid=1: pc<=redir_pc&(DEPTH-1); ifid_valid<=0. Redirect overrides stall, a pending jump and a pending halt.
  2. stall=1: pc and all IF/ID fields hold.
  3. ifid_valid=1 and ifid_instr==8'hFF: state<=HALT; halted<=1; ifid_valid<=0; pc holds.
  4. ifid_valid=1 and ifid_instr is a jump: pc<=target; ifid_valid<=0, which squashes the instruction fetched this cycle.
  5. Otherwise: ifid_instr<=instr_in; ifid_pc<=pc; ifid_valid<=1; pc<=(pc+1)&(DEPTH-1).
- PC arithmetic is 8-bit, masked to DEPTH. Increment from DEPTH-1 wraps to 0. Bits above log2(DEPTH) of pc_out are always 0.
- When ifid_valid=0, ifid_instr and ifid_pc keep their previous values; decode must ignore them.

## Timing

- Fetch latency: instruction at address A appears on ifid_instr one edge after pc_out=A.
- First fetch after reset release: edge 1 moves IDLE→RUN with pc=0. Edge 2 loads IF/ID with mem[0] (ifid_pc=0) and sets pc=1.
- Throughput: one instruction per cycle with no stall, jump or redirect.
- Jump penalty: one bubble. The jump sits in IF/ID in cycle N; edge N+1 loads pc=target and clears ifid_valid; edge N+2 loads mem[target].
- Redirect penalty: one bubble, with the same sequence as a jump.
- Stall + jump in IF/ID: the jump is held and resolves on the first edge with stall=0.
- Stall + halt in IF/ID: the halt is held and takes effect on the first edge with stall=0.
- Reset asserted mid-operation: all outputs return to reset values immediately, without waiting for a clock edge, and state=IDLE. Stall, jump, redirect and halt in progress are discarded.
- halted rises on the same edge that enters HALT.

## Test plan

- Reset then straight-line run, memory {08,41,70,81,0E,4E}: IF/ID shows (pc,instr) = (0,08),(1,41),(2,70),(3,81),(4,0E),(5,4E) on edges 2–7; ifid_valid=0 before edge 2.
- Jump: mem[2]=C5, mem[5]=4E, stall=0. After (2,C5) appears, next edge gives ifid_valid=0 and pc_out=5; the following edge gives (5,4E). mem[3] never reaches IF/ID with ifid_valid=1.
- Stall for 3 cycles while (1,41) is in IF/ID: pc_out stays 2 and IF/ID stays (1,41) valid; fetch resumes with (2,70) one edge after stall drops. Repeat with a jump C5 in IF/ID: the jump is taken only after stall drops.
- Redirect and jump together: C5 in IF/ID with redir_valid=1, redir_pc=8'h23 (DEPTH=32). Required: pc_out=8'h03, ifid_valid=0, and the jump is lost. Also redir_valid=1 with stall=1: redirect is still taken.
- Halt and wrap: mem[31]=08, then halt at mem[1]=FF. Required sequence: pc wraps 31→0, then (0,x),(1,FF) appear, then halted=1 and ifid_valid=0. Further edges change nothing and redir_valid is ignored.
- Async reset mid-run with stall=1: pulse reset low between edges. All outputs are 0 immediately. After release, the fetch sequence restarts exactly as in scenario 1.
